// File: rtl/echo_pkg.sv
// Shared encodings and arithmetic helpers for the echo effect stage.
// Helpers work on a wide signed container so any sample width up to 62 bits fits.
package echo_pkg;

  localparam logic [1:0] GAIN_ZERO     = 2'd0;
  localparam logic [1:0] GAIN_QUARTER  = 2'd1;
  localparam logic [1:0] GAIN_HALF     = 2'd2;
  localparam logic [1:0] GAIN_3QUARTER = 2'd3;

  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Per-sample controls that travel down the pipe with their sample.
  typedef struct packed {
    logic       on;
    logic [1:0] fb;
    logic [1:0] mix;
  } ctrl_t;

  // Shift-only gain: 0, 1/4, 1/2, 3/4.
  function automatic calc_t gain_shift(input calc_t x, input logic [1:0] code);
    calc_t g;
    case (code)
      GAIN_QUARTER:  g = x >>> 2;
      GAIN_HALF:     g = x >>> 1;
      GAIN_3QUARTER: g = (x >>> 1) + (x >>> 2);
      default:       g = '0;
    endcase
    return g;
  endfunction

  // Add and clamp into the signed range of a w-bit sample.
  function automatic calc_t sat_add(input calc_t a, input calc_t b, input int w);
    calc_t s, hi, lo;
    s  = a + b;
    hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    lo = -hi - calc_t'(1);
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// No reset so it maps onto block RAM; read-during-write returns old data.
module sample_ram #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/echo_delay.sv
// Echo effect: circular-buffer delay with shift-based feedback and wet/dry mix.
// Two-stage pipe: S1 registers the sample and issues the RAM read, S2 computes and writes back.
module echo_delay
  import echo_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [WIDTH-1:0]  in_data,
  input  logic                     wren,
  input  logic                     on,
  input  logic        [ADDR_W-1:0] delay_len,
  input  logic        [1:0]        fb,
  input  logic        [1:0]        mix,
  output logic signed [WIDTH-1:0]  out_data,
  output logic                     out_valid
);

  localparam int                STAGES   = 2;
  localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(DEPTH - 1);

  typedef struct packed {
    logic signed [WIDTH-1:0] data;
    ctrl_t                   ctrl;
    logic [ADDR_W-1:0]       waddr;
    logic                    gate;  // history not yet deep enough for this delay
    logic                    fwd;   // read hits the address being written this cycle
  } s1_t;

  logic [STAGES-1:0]       vld_pipe;
  s1_t                     s1;
  logic [ADDR_W-1:0]       wp, fill, dlen, raddr;
  logic                    we;
  logic [WIDTH-1:0]        ram_rdata;
  logic signed [WIDTH-1:0] wdata, fwd_data, wet, result;

  assign dlen      = (delay_len == '0) ? ADDR_W'(1) : delay_len;
  assign raddr     = wp - dlen;
  assign we        = vld_pipe[0] & ~reset;
  assign out_valid = vld_pipe[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp       <= '0;
      fill     <= '0;
      vld_pipe <= '0;
      out_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], wren};
      out_data <= vld_pipe[0] ? result : '0;
      if (wren) begin
        wp <= wp + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

  // S1 payload; stale contents are harmless because vld_pipe qualifies them.
  always_ff @(posedge clk) begin
    if (wren)
      s1 <= '{data:  in_data,
              ctrl:  ctrl_t'{on, fb, mix},
              waddr: wp,
              gate:  fill < dlen,
              fwd:   we && (raddr == s1.waddr)};
    fwd_data <= wdata;
  end

  sample_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (s1.waddr),
    .wdata (wdata),
    .re    (wren),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    wet    = '0;
    wdata  = s1.data;
    result = s1.data;
    if (!s1.gate) wet = s1.fwd ? fwd_data : $signed(ram_rdata);
    if (s1.ctrl.on) begin
      wdata  = WIDTH'(sat_add(calc_t'(s1.data),
                              gain_shift(calc_t'(wet), s1.ctrl.fb), WIDTH));
      result = WIDTH'(sat_add(calc_t'(s1.data) - gain_shift(calc_t'(s1.data), s1.ctrl.mix),
                              gain_shift(calc_t'(wet), s1.ctrl.mix), WIDTH));
    end
  end

endmodule

// File: tb/tb_echo_delay.sv
// Randomized and directed bench for echo_delay against an unbounded-history reference model.
module tb_echo_delay;

  localparam int W  = 24;
  localparam int D  = 16;
  localparam int AW = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 wren = 1'b0;
  logic                 on = 1'b0;
  logic signed [W-1:0]  in_data = '0;
  logic        [AW-1:0] delay_len = '0;
  logic        [1:0]    fb = '0;
  logic        [1:0]    mix = '0;
  logic signed [W-1:0]  out_data;
  logic                 out_valid;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: every written buffer word by absolute sample index, plus a 2-deep latency line.
  longint     hist[$];
  logic [1:0] pv = '0;
  logic [W-1:0] pd [2];
  logic         got_v, ev;
  logic [W-1:0] got_d, ed;

  echo_delay #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .wren      (wren),
    .on        (on),
    .delay_len (delay_len),
    .fb        (fb),
    .mix       (mix),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic longint g(input longint x, input logic [1:0] c);
    case (c)
      2'd1:    return x >>> 2;
      2'd2:    return x >>> 1;
      2'd3:    return (x >>> 1) + (x >>> 2);
      default: return 0;
    endcase
  endfunction

  function automatic longint sat(input longint v);
    if (v > 64'sd8388607)  return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
  endfunction

  // One cycle: capture outputs and their expectation, advance the model, drive new inputs.
  task automatic step(input logic rst, input logic w, input logic [W-1:0] x, input logic o,
                      input logic [AW-1:0] d, input logic [1:0] f, input logic [1:0] m);
    longint xi, wt, wr, res;
    int n, de;
    @(negedge clk);
    got_v = out_valid; got_d = out_data; ev = pv[1]; ed = pd[1];
    pv[1] = pv[0]; pd[1] = pd[0]; pv[0] = 1'b0; pd[0] = '0;
    if (rst) begin
      hist.delete();
      pv = '0; pd[1] = '0;
    end else if (w) begin
      xi = longint'($signed(x));
      n  = hist.size();
      de = (d == 0) ? 1 : int'(d);
      wt = (n >= de) ? hist[n-de] : 0;
      if (o) begin
        wr  = sat(xi + g(wt, f));
        res = sat(xi - g(xi, m) + g(wt, m));
      end else begin
        wr = xi; res = xi;
      end
      hist.push_back(wr);
      pv[0] = 1'b1; pd[0] = W'(res);
    end
    reset = rst; wren = w; in_data = x; on = o; delay_len = d; fb = f; mix = m;
  endtask

  task automatic test_reset();
    step(1, 1, 24'h111111, 1, 4'd1, 2'd1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step(i < 1, 0, '0, 0, 4'd1, 2'd0, 2'd0);
      n_chk++;
      if (got_v !== 1'b0 || got_d !== '0 || ev !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got v=%0b d=%h, want v=0 d=000000", i, got_v, got_d);
      end
    end
  endtask

  task automatic test_bypass();
    step(1, 0, '0, 0, 4'd1, 2'd0, 2'd0);
    step(0, 1, 24'h123456, 0, 4'd3, 2'd2, 2'd2);
    for (int j = 1; j <= 3; j++) begin
      step(0, 0, '0, 0, 4'd3, 2'd2, 2'd2);
      n_chk++;
      if (got_v !== (j == 2) || got_d !== ((j == 2) ? 24'h123456 : 24'h0) || got_d !== ed) begin
        n_fail++;
        $display("FAIL bypass[%0d]: got v=%0b d=%h, want v=%0b d=%h", j, got_v, got_d, j == 2,
                 (j == 2) ? 24'h123456 : 24'h0);
      end
    end
  endtask

  task automatic test_single_echo();
    logic [W-1:0] exp_o [12] = '{24'h200000, 0, 0, 0, 24'h200000, 0, 0, 0, 0, 0, 0, 0};
    step(1, 0, '0, 0, 4'd1, 2'd0, 2'd0);
    for (int i = 0; i < 14; i++) begin
      step(0, i < 12, (i == 0) ? 24'h400000 : 24'h0, 1, 4'd4, 2'd0, 2'd2);
      if (i >= 2) begin
        n_chk++;
        if (got_v !== 1'b1 || got_d !== exp_o[i-2] || got_d !== ed) begin
          n_fail++;
          $display("FAIL single_echo[%0d]: got v=%0b d=%h, want v=1 d=%h", i-2, got_v, got_d, exp_o[i-2]);
        end
      end
    end
  endtask

  task automatic test_feedback();
    logic [W-1:0] exp_o [8] = '{24'h200000, 0, 24'h200000, 0, 24'h100000, 0, 24'h080000, 0};
    step(1, 0, '0, 0, 4'd1, 2'd0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      step(0, i < 8, (i == 0) ? 24'h400000 : 24'h0, 1, 4'd2, 2'd2, 2'd2);
      if (i >= 2) begin
        n_chk++;
        if (got_v !== 1'b1 || got_d !== exp_o[i-2] || got_d !== ed) begin
          n_fail++;
          $display("FAIL feedback[%0d]: got v=%0b d=%h, want v=1 d=%h", i-2, got_v, got_d, exp_o[i-2]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] x;
    for (int p = 0; p < 2; p++) begin
      x = (p == 0) ? 24'h7FFFFF : 24'h800000;
      step(1, 0, '0, 0, 4'd1, 2'd0, 2'd0);
      for (int i = 0; i < 14; i++) begin
        step(0, i < 12, x, 1, 4'd1, 2'd3, 2'd2);
        if (i >= 2) begin
          n_chk++;
          if (got_v !== 1'b1 || got_d !== ed || got_d[W-1] !== (p == 1)) begin
            n_fail++;
            $display("FAIL saturation[%0d.%0d]: got v=%0b d=%h, want v=1 d=%h", p, i-2, got_v, got_d, ed);
          end
        end
      end
    end
  endtask

  task automatic test_fill_gating();
    logic [W-1:0] want;
    step(1, 0, '0, 0, 4'd1, 2'd0, 2'd0);
    for (int i = 0; i < 16; i++) begin
      step(0, i < 14, 24'h010000, 1, 4'd8, 2'd0, 2'd2);
      if (i >= 2) begin
        want = (i - 2 < 8) ? 24'h008000 : 24'h010000;
        n_chk++;
        if (got_v !== 1'b1 || got_d !== want || got_d !== ed) begin
          n_fail++;
          $display("FAIL fill_gating[%0d]: got v=%0b d=%h, want v=1 d=%h", i-2, got_v, got_d, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x0;
    step(1, 0, '0, 0, 4'd1, 2'd0, 2'd0);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, W'($urandom), ($urandom_range(0, 7) != 0), 4'd1, 2'($urandom), 2'($urandom));
      if (i >= 2) begin
        n_chk++;
        if (got_v !== ev || got_d !== ed) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: got v=%0b d=%h, want v=%0b d=%h", i-2, got_v, got_d, ev, ed);
        end
      end
    end
    step(1, 1, 24'h3AAAAA, 1, 4'd1, 2'd3, 2'd3);
    n_chk++;
    if (got_v !== ev || got_d !== ed) begin
      n_fail++;
      $display("FAIL pre_reset_out: got v=%0b d=%h, want v=%0b d=%h", got_v, got_d, ev, ed);
    end
    x0 = W'($urandom);
    step(0, 1, x0, 1, 4'd1, 2'd2, 2'd2);
    n_chk++;
    if (got_v !== 1'b0 || got_d !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_flush: got v=%0b d=%h, want v=0 d=000000", got_v, got_d);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, i < 4, W'($urandom), 1, 4'd1, 2'd2, 2'd2);
      if (i == 1) begin
        n_chk++;
        if (got_v !== 1'b1 || got_d !== W'(longint'($signed(x0)) - (longint'($signed(x0)) >>> 1))) begin
          n_fail++;
          $display("FAIL post_reset_first: got v=%0b d=%h, want v=1 d=%h", got_v, got_d,
                   W'(longint'($signed(x0)) - (longint'($signed(x0)) >>> 1)));
        end
      end
      n_chk++;
      if (got_v !== ev || got_d !== ed) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: got v=%0b d=%h, want v=%0b d=%h", i, got_v, got_d, ev, ed);
      end
    end
  endtask

  task automatic test_random();
    step(1, 0, '0, 0, 4'd1, 2'd0, 2'd0);
    for (int i = 0; i < 300; i++) begin
      step(0, ($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 5) != 0),
           AW'($urandom), 2'($urandom), 2'($urandom));
      n_chk++;
      if (got_v !== ev || got_d !== ed) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0b d=%h, want v=%0b d=%h", i, got_v, got_d, ev, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_single_echo();
    test_feedback();
    test_saturation();
    test_fill_gating();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
